// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch types and constants
package riscv_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} fetch_state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [XLEN_DEFAULT-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch FIFO of fetched words with flush
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int AW = $clog2(QDEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) mem[i] <= '{instr: NOP_INSTR, pc: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head = mem[rd_ptr];
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && !flush && count == CW'(QDEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, imem requests and prefetch queue feeding decode
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int QDEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic            misalign_err
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int OW = CW + 1;
    fetch_state_t state, state_next;
    logic [XLEN-1:0] fpc, issue_pc;
    logic inflight, drop, pop, push;
    logic [CW-1:0] count;
    logic [OW-1:0] occ;
    fetch_entry_t head, push_data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            fpc <= RESET_PC;
            issue_pc <= '0;
            inflight <= 1'b0;
            drop <= 1'b0;
        end else begin
            state <= state_next;
            inflight <= imem_en;
            drop <= redirect_valid && imem_en;
            fpc <= redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : imem_en ? fpc + XLEN'(4) : fpc;
            if (imem_en) issue_pc <= fpc;
        end
    end
    always_comb begin
        state_next = redirect_valid ? S_FLUSH : S_RUN;
        occ = OW'(count) - OW'(pop) + OW'(inflight);
        imem_en = state != S_IDLE && !redirect_valid && occ < OW'(QDEPTH);
    end
    assign imem_addr = fpc;
    assign if_valid = count != '0 && !redirect_valid;
    assign pop = if_valid && id_ready;
    assign push = inflight && !drop && state != S_FLUSH;
    assign push_data = '{instr: imem_rdata, pc: issue_pc};
    assign if_instr = head.instr;
    assign if_pc = head.pc;
    assign if_pc_plus4 = count != '0 ? head.pc + XLEN'(4) : '0;
    assign misalign_err = redirect_valid && |redirect_pc[1:0];
    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk(clk),
        .rst_n(rst_n),
        .flush(redirect_valid),
        .push(push),
        .push_data(push_data),
        .pop(pop),
        .head(head),
        .count(count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, stall, redirect, reset and wrap
module tb_fetch_unit;
    logic clk = 0, rst_n = 0, imem_en, redirect_valid = 0, id_ready = 0, if_valid, misalign_err;
    logic [31:0] imem_addr, imem_rdata, redirect_pc = 0, if_instr, if_pc, if_pc_plus4;
    int checks = 0, errors = 0, nissue = 0;
    always #5 clk = ~clk;
    fetch_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4),
        .misalign_err(misalign_err)
    );
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction
    always @(posedge clk) imem_rdata <= imem_en ? word(imem_addr) : 32'hDEAD_BEEF;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic head(input string tag, input logic [31:0] pc);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        chk({tag, "_valid"}, if_valid, 1);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_instr"}, if_instr, word(pc));
        chk({tag, "_pc4"}, if_pc_plus4, pc4);
    endtask
    task automatic issue(input string tag, input logic [31:0] a);
        chk({tag, "_en"}, imem_en, 1);
        chk({tag, "_addr"}, imem_addr, a);
    endtask
    task automatic rst_vals(input string tag);
        chk({tag, "_en"}, imem_en, 0);
        chk({tag, "_valid"}, if_valid, 0);
        chk({tag, "_instr"}, if_instr, 32'h0000_0013);
        chk({tag, "_pc"}, if_pc, 0);
        chk({tag, "_pc4"}, if_pc_plus4, 0);
        chk({tag, "_mis"}, misalign_err, 0);
    endtask
    initial begin
        repeat (2) cyc();
        rst_n = 1; id_ready = 1; #1;
        rst_vals("reset");
        cyc(); #1; issue("first", 32'hBFC0_0000); chk("first_nv", if_valid, 0);
        cyc(); #1; issue("second", 32'hBFC0_0004); chk("second_nv", if_valid, 0);
        cyc(); #1; head("h0", 32'hBFC0_0000); issue("c3", 32'hBFC0_0008);
        cyc(); #1; head("h1", 32'hBFC0_0004);
        cyc(); #1; head("h2", 32'hBFC0_0008); issue("c5", 32'hBFC0_0010);
        cyc(); redirect_valid = 1; redirect_pc = 32'h0000_0100; #1;
        chk("rd_nv", if_valid, 0); chk("rd_noen", imem_en, 0); chk("rd_mis", misalign_err, 0);
        cyc(); redirect_valid = 0; #1; issue("rd_t1", 32'h0000_0100); chk("rd_t1_nv", if_valid, 0);
        cyc(); #1; chk("rd_t2_nv", if_valid, 0);
        cyc(); #1; head("rd_t3", 32'h0000_0100);
        cyc(); #1; head("rd_t4", 32'h0000_0104);
        cyc(); redirect_valid = 1; redirect_pc = 32'h0000_0102; #1;
        chk("mis_pulse", misalign_err, 1); chk("mis_nv", if_valid, 0);
        cyc(); redirect_valid = 0; #1; chk("mis_clear", misalign_err, 0); issue("mis_t1", 32'h0000_0100);
        cyc(); cyc(); #1; head("mis_t3", 32'h0000_0100);
        cyc(); redirect_valid = 1; redirect_pc = 32'h0000_0200; #1;
        cyc(); redirect_pc = 32'h0000_0300; #1; chk("b2b_nv", if_valid, 0); chk("b2b_noen", imem_en, 0);
        cyc(); redirect_valid = 0; #1; issue("b2b_t1", 32'h0000_0300);
        cyc(); #1; chk("b2b_t2_nv", if_valid, 0);
        cyc(); #1; head("b2b_t3", 32'h0000_0300);
        cyc(); redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; #1;
        cyc(); redirect_valid = 0; #1; issue("wrap_t1", 32'hFFFF_FFFC);
        cyc(); #1; issue("wrap_t2", 32'h0000_0000);
        cyc(); #1; head("wrap_t3", 32'hFFFF_FFFC);
        cyc(); #1; head("wrap_t4", 32'h0000_0000);
        cyc(); id_ready = 0; #1; head("wrap_t5", 32'h0000_0004);
        cyc(); #1; head("full", 32'h0000_0004); chk("full_noen", imem_en, 0);
        cyc(); rst_n = 0; #1;
        cyc(); rst_n = 1; #1; rst_vals("midrst");
        nissue = 0;
        cyc(); #1; issue("rs_t1", 32'hBFC0_0000); nissue += int'(imem_en);
        cyc(); #1; issue("rs_t2", 32'hBFC0_0004); nissue += int'(imem_en);
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            head($sformatf("stall%0d", i), 32'hBFC0_0000);
            nissue += int'(imem_en);
        end
        chk("stall_issues", nissue, 2);
        cyc(); id_ready = 1; #1; head("rel0", 32'hBFC0_0000); issue("rel_issue", 32'hBFC0_0008);
        cyc(); #1; head("rel1", 32'hBFC0_0004);
        cyc(); #1; head("rel2", 32'hBFC0_0008);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
